// File: rtl/aes128_sub_bytes_serial.sv
// Byte-serial AES SubBytes engine.
// A start pulse captures an N_BYTES word. One substituted byte is then
// streamed per clock with its index, and the last byte is flagged with done_o.
// The substitution comes from an internal FIPS-197 S-box ROM, or from a
// shared external S-box through the sbox_sub_o / sbox_sub_i ports.
module aes128_sub_bytes_serial #(
   parameter int unsigned N_BYTES       = 16,
   parameter bit          EXTERNAL_SBOX = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [N_BYTES*8-1:0] data_i,
   input  logic                 start_i,
   output logic [7:0]           data_o,
   output logic [3:0]           addr_o,
   output logic                 valid_o,
   output logic                 done_o,
   output logic [7:0]           sbox_sub_o,
   input  logic [7:0]           sbox_sub_i
);

   localparam logic [3:0] LAST = 4'(N_BYTES - 1);

   // Forward S-box. Entry 0 is in the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [3:0]           cnt;
   logic [3:0]           cnt_next;
   logic [N_BYTES*8-1:0] word;
   logic [7:0]           cur_byte;

   // State, byte counter and captured word registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         cnt   <= '0;
         word  <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (start_i) begin
            word <= data_i;
         end
      end
   end

   // Next-state logic. A start restarts from byte 0 in either state.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_next = BUSY;
               cnt_next   = '0;
            end
         end
         BUSY: begin
            if (start_i) begin
               cnt_next = '0;
            end else if (cnt == LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 4'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Select the captured byte addressed by the counter.
   // A compare loop avoids index-width mismatches for small N_BYTES.
   always_comb begin
      cur_byte = '0;
      for (int unsigned k = 0; k < N_BYTES; k++) begin
         if (cnt == 4'(k)) begin
            cur_byte = word[8*k +: 8];
         end
      end
   end

   // Output stage. All outputs are forced to zero outside BUSY.
   always_comb begin
      valid_o    = 1'b0;
      done_o     = 1'b0;
      addr_o     = '0;
      sbox_sub_o = '0;
      data_o     = '0;
      if (state == BUSY) begin
         valid_o    = 1'b1;
         done_o     = (cnt == LAST);
         addr_o     = cnt;
         sbox_sub_o = cur_byte;
         data_o     = EXTERNAL_SBOX ? sbox_sub_i : SBOX[cur_byte];
      end
   end

endmodule

// File: tb/tb_aes128_sub_bytes_serial.sv
// Testbench for aes128_sub_bytes_serial.
// Three instances are exercised:
//   4-byte internal S-box, 16-byte internal S-box, and 4-byte external S-box.
// The reference S-box is computed from the GF(2^8) inverse and the affine map.
module tb_aes128_sub_bytes_serial;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start4, start16, startx;
   logic [31:0]  data4, datax;
   logic [127:0] data16;
   logic [7:0]   d4, d16, dx, s4, s16, sx, ext_res;
   logic [3:0]   a4, a16, ax;
   logic         v4, v16, vx, dn4, dn16, dnx;
   logic [7:0]   zero_sbox = 8'h00;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   // External S-box model: bitwise inversion of the raw byte.
   assign ext_res = sx ^ 8'hFF;

   aes128_sub_bytes_serial #(.N_BYTES(4), .EXTERNAL_SBOX(1'b0)) u4 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(data4), .start_i(start4),
      .data_o(d4), .addr_o(a4), .valid_o(v4), .done_o(dn4),
      .sbox_sub_o(s4), .sbox_sub_i(zero_sbox)
   );

   aes128_sub_bytes_serial #(.N_BYTES(16), .EXTERNAL_SBOX(1'b0)) u16 (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(data16), .start_i(start16),
      .data_o(d16), .addr_o(a16), .valid_o(v16), .done_o(dn16),
      .sbox_sub_o(s16), .sbox_sub_i(zero_sbox)
   );

   aes128_sub_bytes_serial #(.N_BYTES(4), .EXTERNAL_SBOX(1'b1)) ux (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(datax), .start_i(startx),
      .data_o(dx), .addr_o(ax), .valid_o(vx), .done_o(dnx),
      .sbox_sub_o(sx), .sbox_sub_i(ext_res)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S(x) = affine(x^254): x^254 is the multiplicative inverse, and 0 maps to 0.
   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic int nbytes(input int which);
      return (which == 1) ? 16 : 4;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int which, output logic [7:0] d, output logic [3:0] a,
                         output logic v, output logic dn, output logic [7:0] s);
      case (which)
         0:       begin d = d4;  a = a4;  v = v4;  dn = dn4;  s = s4;  end
         1:       begin d = d16; a = a16; v = v16; dn = dn16; s = s16; end
         default: begin d = dx;  a = ax;  v = vx;  dn = dnx;  s = sx;  end
      endcase
   endtask

   // Drive a start pulse with word w, and consume the capture edge.
   // Afterwards byte 0 is on the outputs and data_i holds garbage.
   task automatic start_op(input int which, input logic [127:0] w);
      case (which)
         0:       begin data4  = w[31:0]; start4  = 1'b1; end
         1:       begin data16 = w;       start16 = 1'b1; end
         default: begin datax  = w[31:0]; startx  = 1'b1; end
      endcase
      tick();
      start4  = 1'b0;
      start16 = 1'b0;
      startx  = 1'b0;
      data4   = $urandom;
      datax   = $urandom;
      data16  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic expect_byte(input int which, input logic [127:0] w, input int k);
      logic [7:0] d, s, b, exp_d;
      logic [3:0] a;
      logic       v, dn;
      b     = w[8*k +: 8];
      exp_d = (which == 2) ? (b ^ 8'hFF) : sbox_ref(b);
      sample(which, d, a, v, dn, s);
      chk($sformatf("i%0d_k%0d_valid", which, k), {31'd0, v}, 32'd1);
      chk($sformatf("i%0d_k%0d_addr", which, k), {28'd0, a}, k);
      chk($sformatf("i%0d_k%0d_sub", which, k), {24'd0, s}, {24'd0, b});
      chk($sformatf("i%0d_k%0d_data", which, k), {24'd0, d}, {24'd0, exp_d});
      chk($sformatf("i%0d_k%0d_done", which, k), {31'd0, dn}, (k == nbytes(which) - 1) ? 32'd1 : 32'd0);
   endtask

   task automatic expect_idle(input int which, input string tag);
      logic [7:0] d, s;
      logic [3:0] a;
      logic       v, dn;
      sample(which, d, a, v, dn, s);
      chk($sformatf("%s_i%0d_valid", tag, which), {31'd0, v}, 32'd0);
      chk($sformatf("%s_i%0d_done", tag, which), {31'd0, dn}, 32'd0);
      chk($sformatf("%s_i%0d_addr", tag, which), {28'd0, a}, 32'd0);
      chk($sformatf("%s_i%0d_data", tag, which), {24'd0, d}, 32'd0);
      chk($sformatf("%s_i%0d_sub", tag, which), {24'd0, s}, 32'd0);
   endtask

   task automatic run_op(input int which, input logic [127:0] w);
      start_op(which, w);
      for (int k = 0; k < nbytes(which); k++) begin
         expect_byte(which, w, k);
         tick();
      end
      expect_idle(which, "post");
   endtask

   initial begin
      logic [127:0] w;
      logic [7:0]   d, s;
      logic [3:0]   a;
      logic         v, dn;
      int           vcount, dcount;

      rst_n   = 1'b0;
      start4  = 1'b0;
      start16 = 1'b0;
      startx  = 1'b0;
      data4   = '0;
      data16  = '0;
      datax   = '0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) expect_idle(i, "reset");
      rst_n = 1'b1;
      tick();

      // SubWord vector and the external S-box vector.
      run_op(0, 128'h0953FF00);
      run_op(2, 128'h44332211);

      // Full 16-byte state 00..0F; count valid and done cycles over a wide window.
      w = 128'h0F0E0D0C0B0A09080706050403020100;
      start_op(1, w);
      vcount = 0;
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         sample(1, d, a, v, dn, s);
         if (v === 1'b1) vcount++;
         if (dn === 1'b1) dcount++;
         if (i < 16) expect_byte(1, w, i);
         tick();
      end
      chk("full_valid_cycles", vcount, 16);
      chk("full_done_cycles", dcount, 1);

      // Random words on every instance.
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < 3; i++) begin
            run_op(i, {$urandom, $urandom, $urandom, $urandom});
         end
      end

      // Restart at addr 1 with an all-ones word.
      w = {96'd0, $urandom};
      start_op(0, w);
      expect_byte(0, w, 0);
      tick();
      expect_byte(0, w, 1);
      start_op(0, 128'hFFFFFFFF);
      for (int k = 0; k < 4; k++) begin
         expect_byte(0, 128'hFFFFFFFF, k);
         tick();
      end
      expect_idle(0, "restart");

      // Back-to-back: start during the done cycle, with no gap cycle.
      for (int i = 0; i < 3; i++) begin
         logic [127:0] wa, wb;
         wa = {$urandom, $urandom, $urandom, $urandom};
         wb = {$urandom, $urandom, $urandom, $urandom};
         start_op(i, wa);
         for (int k = 0; k < nbytes(i) - 1; k++) begin
            expect_byte(i, wa, k);
            tick();
         end
         expect_byte(i, wa, nbytes(i) - 1);
         start_op(i, wb);
         for (int k = 0; k < nbytes(i); k++) begin
            expect_byte(i, wb, k);
            tick();
         end
         expect_idle(i, "b2b");
      end

      // Reset mid-operation at addr 2: outputs clear and no done follows.
      w = {96'd0, $urandom};
      start_op(0, w);
      for (int k = 0; k < 2; k++) begin
         expect_byte(0, w, k);
         tick();
      end
      expect_byte(0, w, 2);
      rst_n = 1'b0;
      tick();
      expect_idle(0, "midrst");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_idle(0, "afterrst");
      end
      run_op(0, {96'd0, $urandom});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
